// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch stage and its neighbours.
package cpu_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  // Decode substitutes this word for the instruction slot killed by a flush.
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Fetch-stage bundle: instruction-memory port, EX redirect and decode handshake.
interface ifetch_prefetch_if #(
  parameter int XLEN = 32
);
  import cpu_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_pc4;
  logic [INST_W-1:0] out_inst;
  logic              flush;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_pc4, out_inst, flush,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_pc4, out_inst, flush,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_fbuf.sv
// Fetch buffer: circular entry store with allocate (request), fill (response) and head (pop) pointers.
module ifetch_fbuf
  import cpu_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int FQ_DEPTH = 4,
  localparam int PW       = $clog2(FQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              alloc_en,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              fill_en,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop_en,
  output logic [PW-1:0]     occ,
  output logic [PW-1:0]     outstanding,
  output logic              head_filled,
  output logic [XLEN-1:0]   head_pc,
  output logic [XLEN-1:0]   head_pc4,
  output logic [INST_W-1:0] head_inst
);

  localparam int IW = PW - 1;

  logic [PW-1:0]     alloc_ptr_r, fill_ptr_r, head_ptr_r;
  logic [XLEN-1:0]   pc_r   [FQ_DEPTH];
  logic [XLEN-1:0]   pc4_r  [FQ_DEPTH];
  logic [INST_W-1:0] inst_r [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] filled_r;

  logic [IW-1:0] alloc_idx_s, fill_idx_s, head_idx_s;

  assign alloc_idx_s = alloc_ptr_r[IW-1:0];
  assign fill_idx_s  = fill_ptr_r[IW-1:0];
  assign head_idx_s  = head_ptr_r[IW-1:0];

  assign occ         = alloc_ptr_r - head_ptr_r;
  assign outstanding = alloc_ptr_r - fill_ptr_r;
  assign head_filled = filled_r[head_idx_s];
  assign head_pc     = pc_r[head_idx_s];
  assign head_pc4    = pc4_r[head_idx_s];
  assign head_inst   = inst_r[head_idx_s];

  // Entry store and pointers; the three index targets never collide while the credit limit holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_ptr_r <= {PW{1'b0}};
      fill_ptr_r  <= {PW{1'b0}};
      head_ptr_r  <= {PW{1'b0}};
      filled_r    <= {FQ_DEPTH{1'b0}};
      for (int i = 0; i < FQ_DEPTH; i++) begin
        pc_r[i]   <= {XLEN{1'b0}};
        pc4_r[i]  <= {XLEN{1'b0}};
        inst_r[i] <= {INST_W{1'b0}};
      end
    end else if (clear) begin
      alloc_ptr_r <= {PW{1'b0}};
      fill_ptr_r  <= {PW{1'b0}};
      head_ptr_r  <= {PW{1'b0}};
      filled_r    <= {FQ_DEPTH{1'b0}};
    end else begin
      if (alloc_en) begin
        pc_r[alloc_idx_s]     <= alloc_pc;
        pc4_r[alloc_idx_s]    <= alloc_pc + XLEN'(PC_STEP);
        filled_r[alloc_idx_s] <= 1'b0;
        alloc_ptr_r           <= alloc_ptr_r + PW'(1);
      end
      if (fill_en) begin
        inst_r[fill_idx_s]   <= fill_inst;
        filled_r[fill_idx_s] <= 1'b1;
        fill_ptr_r           <= fill_ptr_r + PW'(1);
      end
      if (pop_en) begin
        filled_r[head_idx_s] <= 1'b0;
        head_ptr_r           <= head_ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ifetch_prefetch_chk.sv
// Protocol checker for the fetch stage's memory-response port.
module ifetch_prefetch_chk (
  input logic clk,
  input logic reset,
  input logic resp_valid,
  input logic drop_zero,
  input logic none_outstanding
);

  // A response with nothing to drop and nothing outstanding has no owner.
  a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
    !(resp_valid && drop_zero && none_outstanding));

endmodule

// File: rtl/ifetch_prefetch.sv
// Prefetching fetch stage: sequential requests under a credit limit, in-order buffering, redirect with stale-response dropping.
module ifetch_prefetch
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              FQ_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  ifetch_prefetch_if.master  bus
);

  localparam int            PW      = $clog2(FQ_DEPTH) + 1;
  localparam logic [PW:0]   DEPTH_L = (PW + 1)'(FQ_DEPTH);

  logic [XLEN-1:0] fetch_pc_r;
  logic [PW-1:0]   drop_cnt_r;
  logic            flush_r;

  logic [PW-1:0]   occ_s, outstanding_s, drop_sum_s, drop_next_s;
  logic            head_filled_s, credit_ok_s, req_valid_s, req_fire_s;
  logic            drop_s, fill_s, out_valid_s, pop_s;
  logic [XLEN-1:0] head_pc_s, head_pc4_s;
  logic [INST_W-1:0] head_inst_s;

  // Stale responses still owed by memory hold credits just like live entries.
  always_comb begin
    credit_ok_s = ({1'b0, occ_s} + {1'b0, drop_cnt_r}) < DEPTH_L;
    req_valid_s = !reset && !bus.redirect_valid && credit_ok_s;
    req_fire_s  = req_valid_s && bus.imem_req_ready;
    drop_s      = bus.imem_resp_valid && (drop_cnt_r != {PW{1'b0}});
    fill_s      = bus.imem_resp_valid && (drop_cnt_r == {PW{1'b0}}) &&
                  (outstanding_s != {PW{1'b0}}) && !bus.redirect_valid;
    out_valid_s = head_filled_s && (occ_s != {PW{1'b0}}) && !bus.redirect_valid;
    pop_s       = out_valid_s && bus.out_ready;
  end

  // Next drop count; a response landing in the redirect cycle is itself stale.
  always_comb begin
    drop_sum_s = drop_cnt_r + outstanding_s;
    if (bus.redirect_valid) begin
      if (bus.imem_resp_valid && (drop_sum_s != {PW{1'b0}})) begin
        drop_next_s = drop_sum_s - PW'(1);
      end else begin
        drop_next_s = drop_sum_s;
      end
    end else if (drop_s) begin
      drop_next_s = drop_cnt_r - PW'(1);
    end else begin
      drop_next_s = drop_cnt_r;
    end
  end

  // Fetch PC, stale-response counter and one-cycle flush pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      drop_cnt_r <= {PW{1'b0}};
      flush_r    <= 1'b0;
    end else begin
      flush_r    <= bus.redirect_valid;
      drop_cnt_r <= drop_next_s;
      if (bus.redirect_valid) begin
        fetch_pc_r <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(PC_STEP);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

  ifetch_fbuf #(
    .XLEN     (XLEN),
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fbuf (
    .clk         (clk),
    .reset       (reset),
    .clear       (bus.redirect_valid),
    .alloc_en    (req_fire_s),
    .alloc_pc    (fetch_pc_r),
    .fill_en     (fill_s),
    .fill_inst   (bus.imem_resp_data),
    .pop_en      (pop_s),
    .occ         (occ_s),
    .outstanding (outstanding_s),
    .head_filled (head_filled_s),
    .head_pc     (head_pc_s),
    .head_pc4    (head_pc4_s),
    .head_inst   (head_inst_s)
  );

  ifetch_prefetch_chk u_chk (
    .clk              (clk),
    .reset            (reset),
    .resp_valid       (bus.imem_resp_valid),
    .drop_zero        (drop_cnt_r == {PW{1'b0}}),
    .none_outstanding (outstanding_s == {PW{1'b0}})
  );

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.out_valid      = out_valid_s;
  assign bus.out_pc         = head_pc_s;
  assign bus.out_pc4        = head_pc4_s;
  assign bus.out_inst       = head_inst_s;
  assign bus.flush          = flush_r;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: in-order memory model with tagged epochs and a program-order reference.
module tb_ifetch_prefetch;
  import cpu_pkg::*;

  localparam int          FQ     = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_prefetch_if #(.XLEN(32)) bus ();

  ifetch_prefetch #(.XLEN(32), .RESET_PC(RST_PC), .FQ_DEPTH(FQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc, lat_min, lat_max, live, epoch, last_due;
  mreq_t       mq[$];
  logic [31:0] ret_q[$];
  logic [31:0] exp_req_pc;
  logic        prev_rdr;

  logic        obs_req_valid, obs_req_fire, obs_out_valid, obs_out_fire, obs_flush;
  logic [31:0] obs_addr, obs_out_pc, obs_out_pc4;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return NOP_INST ^ {a[15:0], ~a[15:0]};
  endfunction

  task automatic model_clear();
    mq.delete();
    ret_q.delete();
    live = 0; epoch = 0; last_due = 0; cyc = 0;
    exp_req_pc = RST_PC;
    prev_rdr = 1'b0;
  endtask

  task automatic drive_idle();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.out_ready       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, compare DUT against the reference, advance the reference.
  task automatic run_cycle(input logic rdr, input logic [31:0] rpc, input logic ordy, input logic rrdy);
    int    stale;
    int    l;
    logic  have_resp, exp_rv, exp_ov;
    mreq_t r;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ordy;
    bus.imem_req_ready = rrdy;
    have_resp = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_resp_valid = have_resp;
    bus.imem_resp_data  = have_resp ? inst_of(mq[0].addr) : 32'h0;
    #1;
    stale = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
    exp_rv = !rdr && ((live + stale) < FQ);
    exp_ov = !rdr && (ret_q.size() > 0);
    obs_req_valid = bus.imem_req_valid;
    obs_req_fire  = bus.imem_req_valid && rrdy;
    obs_addr      = bus.imem_req_addr;
    obs_out_valid = bus.out_valid;
    obs_out_fire  = bus.out_valid && ordy;
    obs_out_pc    = bus.out_pc;
    obs_out_pc4   = bus.out_pc4;
    obs_flush     = bus.flush;
    n_checks++;
    if (bus.imem_req_valid !== exp_rv) begin
      n_errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_rv);
    end
    n_checks++;
    if (bus.out_valid !== exp_ov) begin
      n_errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_ov);
    end
    n_checks++;
    if (bus.flush !== prev_rdr) begin
      n_errors++;
      $display("FAIL flush cyc=%0d got=%b exp=%b", cyc, bus.flush, prev_rdr);
    end
    if (ret_q.size() > 0) begin
      n_checks++;
      if (bus.out_pc !== ret_q[0] || bus.out_pc4 !== ret_q[0] + 32'd4 || bus.out_inst !== inst_of(ret_q[0])) begin
        n_errors++;
        $display("FAIL head cyc=%0d got pc=%h pc4=%h inst=%h exp pc=%h pc4=%h inst=%h", cyc,
                 bus.out_pc, bus.out_pc4, bus.out_inst, ret_q[0], ret_q[0] + 32'd4, inst_of(ret_q[0]));
      end
    end
    if (exp_ov && ordy) begin
      void'(ret_q.pop_front());
      live--;
    end
    if (have_resp) begin
      r = mq.pop_front();
      if (!rdr && r.epoch == epoch) ret_q.push_back(r.addr);
    end
    if (rdr) begin
      epoch++;
      ret_q.delete();
      live = 0;
      exp_req_pc = rpc & 32'hFFFF_FFFC;
    end else if (exp_rv && rrdy) begin
      n_checks++;
      if (bus.imem_req_addr !== exp_req_pc) begin
        n_errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, exp_req_pc);
      end
      l = $urandom_range(lat_max, lat_min);
      r.addr = exp_req_pc; r.epoch = epoch; r.due = cyc + l;
      if (r.due < last_due) r.due = last_due;
      last_due = r.due;
      mq.push_back(r);
      live++;
      exp_req_pc = exp_req_pc + 32'd4;
    end
    prev_rdr = rdr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #3;
    n_checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.flush !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctl got req_valid=%b out_valid=%b flush=%b exp 0 0 0",
               bus.imem_req_valid, bus.out_valid, bus.flush);
    end
    n_checks++;
    if (bus.out_pc !== 32'h0 || bus.out_pc4 !== 32'h0 || bus.out_inst !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_data got pc=%h pc4=%h inst=%h exp all 0", bus.out_pc, bus.out_pc4, bus.out_inst);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_stream();
    int first_req, first_out, pops;
    do_reset();
    lat_min = 1; lat_max = 1;
    first_req = -1; first_out = -1; pops = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_req_fire && first_req < 0) first_req = i;
      if (obs_out_valid && first_out < 0) begin
        first_out = i;
        n_checks++;
        if (obs_out_pc !== 32'h0 || obs_out_pc4 !== 32'h4) begin
          n_errors++;
          $display("FAIL stream_first got pc=%h pc4=%h exp 0 4", obs_out_pc, obs_out_pc4);
        end
      end
      if (i >= 10 && obs_out_fire) pops++;
    end
    n_checks++;
    if (first_req !== 0 || first_out - first_req !== 2) begin
      n_errors++;
      $display("FAIL stream_latency got req=%0d out=%0d exp req=0 latency 2", first_req, first_out);
    end
    n_checks++;
    if (pops !== 20) begin
      n_errors++;
      $display("FAIL stream_rate got=%0d exp=20", pops);
    end
  endtask

  task automatic test_stall();
    int reqs;
    logic [31:0] got[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (obs_req_fire) reqs++;
      if (obs_out_valid) begin
        n_checks++;
        if (obs_out_pc !== 32'h0) begin
          n_errors++;
          $display("FAIL stall_hold got=%h exp=0", obs_out_pc);
        end
      end
    end
    n_checks++;
    if (reqs !== FQ || obs_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_credit got reqs=%0d req_valid=%b exp reqs=%0d req_valid=0", reqs, obs_req_valid, FQ);
    end
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_out_fire) got.push_back(obs_out_pc);
    end
    n_checks++;
    if (got.size() !== FQ) begin
      n_errors++;
      $display("FAIL stall_drain_count got=%0d exp=%0d", got.size(), FQ);
    end
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== RST_PC + 32'(4 * i)) begin
        n_errors++;
        $display("FAIL stall_drain_order idx=%0d got=%h exp=%h", i, got[i], RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_drop();
    int first_out;
    do_reset();
    lat_min = 3; lat_max = 3;
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    run_cycle(1'b1, 32'h100, 1'b1, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (obs_req_fire !== 1'b1 || obs_addr !== 32'h100 || obs_flush !== 1'b1) begin
      n_errors++;
      $display("FAIL redir_resume got fire=%b addr=%h flush=%b exp 1 100 1", obs_req_fire, obs_addr, obs_flush);
    end
    first_out = -1;
    for (int i = 0; i < 15; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (i == 0) begin
        n_checks++;
        if (obs_flush !== 1'b0) begin
          n_errors++;
          $display("FAIL redir_flush_len got=%b exp=0", obs_flush);
        end
      end
      if (obs_out_valid && first_out < 0) begin
        first_out = i;
        n_checks++;
        if (obs_out_pc !== 32'h100) begin
          n_errors++;
          $display("FAIL redir_first got=%h exp=100", obs_out_pc);
        end
      end
    end
    n_checks++;
    if (first_out < 0) begin
      n_errors++;
      $display("FAIL redir_no_output got=none exp=out_valid within 15 cycles");
    end
  endtask

  task automatic test_collision();
    logic setup_ok;
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    setup_ok = (mq.size() > 0) && (mq[0].due <= cyc) && (ret_q.size() > 0);
    n_checks++;
    if (!setup_ok) begin
      n_errors++;
      $display("FAIL collide_setup got resp/head not both pending exp both pending");
    end
    run_cycle(1'b1, 32'h200, 1'b1, 1'b1);
    n_checks++;
    if (obs_out_fire !== 1'b0 || obs_req_fire !== 1'b0) begin
      n_errors++;
      $display("FAIL collide_no_hs got pop=%b req=%b exp 0 0", obs_out_fire, obs_req_fire);
    end
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0, (i > 3), 1'b1);
  endtask

  task automatic test_misalign_wrap();
    logic [31:0] got[$];
    logic [31:0] got4[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    run_cycle(1'b1, 32'h103, 1'b1, 1'b1);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (obs_req_fire !== 1'b1 || obs_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL misalign_req got fire=%b addr=%h exp 1 100", obs_req_fire, obs_addr);
    end
    run_cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_out_fire) begin
        got.push_back(obs_out_pc);
        got4.push_back(obs_out_pc4);
      end
    end
    n_checks++;
    if (got.size() < 2 || got[0] !== 32'hFFFF_FFFC || got4[0] !== 32'h0 || got[1] !== 32'h0 || got4[1] !== 32'h4) begin
      n_errors++;
      $display("FAIL wrap got n=%0d first=%h/%h second=%h/%h exp fffffffc/0 0/4", got.size(),
               (got.size() > 0) ? got[0] : 32'hx, (got.size() > 0) ? got4[0] : 32'hx,
               (got.size() > 1) ? got[1] : 32'hx, (got.size() > 1) ? got4[1] : 32'hx);
    end
  endtask

  task automatic test_random();
    int pops;
    logic rdr;
    logic [31:0] tgt;
    do_reset();
    lat_min = 1; lat_max = 4;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      rdr = ($urandom_range(29, 0) == 0) || (prev_rdr && ($urandom_range(1, 0) == 1));
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      run_cycle(rdr, tgt, ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
      if (obs_out_fire) pops++;
    end
    n_checks++;
    if (pops < 200) begin
      n_errors++;
      $display("FAIL random_progress got=%0d exp>=200", pops);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if (obs_out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_setup got out_valid=%b exp=1", obs_out_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL areset_now got req_valid=%b out_valid=%b pc=%h exp 0 0 0",
               bus.imem_req_valid, bus.out_valid, bus.out_pc);
    end
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++;
    if (obs_req_fire !== 1'b1 || obs_addr !== RST_PC) begin
      n_errors++;
      $display("FAIL areset_first got fire=%b addr=%h exp 1 %h", obs_req_fire, obs_addr, RST_PC);
    end
  endtask

  initial begin
    lat_min = 1; lat_max = 1;
    model_clear();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_collision();
    test_misalign_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
